branch_target_buffer: RTL and testbench
=======================================

Name: branch_target_buffer

Overview:
Direct-mapped branch target buffer with 2-bit saturating direction counters, sitting directly upstream of the fetch stage.
- Combinationally supplies predicted_pc and a take-prediction for the current fetch PC; fetch control uses these to select the btb_pc PC-mux source.
- Trained synchronously by the execute stage with resolved branch/jump outcomes.
- Architectural state: valid bits, tags, targets, counters, all held in flops.

Parameters:
ENTRIES, 16, number of BTB entries; power of two, at least 2.
IDX_W, $clog2(ENTRIES), index width; derived, not overridden.
TAG_W, 30-IDX_W, tag width; derived, not overridden.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-low
fetch_valid  input  1  fetch is issuing a lookup this cycle
fetch_pc  input  32  current PC (fetch pc_out)
predict_taken  output  1  BTB hit with counter in a taken state
predicted_pc  output  32  target if predict_taken, else fetch_pc+4
upd_valid  input  1  EX resolves a control-flow instruction this cycle
upd_pc  input  32  PC of the resolved instruction (ex_pc)
upd_taken  input  1  resolved direction
upd_target  input  32  resolved target (br_out or alu_out&~1)
flush  input  1  invalidate all entries
perf_hits  output  32  lookup hit counter (see Optional Feature)
perf_allocs  output  32  allocation counter (see Optional Feature)

Behaviour:
- Index and tag:
  - idx = pc[IDX_W+1:2]
  - tag = pc[31:IDX_W+2]
  - pc[1:0] is ignored.
- Lookup (purely combinational, zero latency from fetch_pc):
  - hit = valid[idx] && tag[idx]==fetch_tag.
  - predict_taken = hit && ctr[idx][1]; it is independent of fetch_valid.
  - predicted_pc = predict_taken ? target[idx] : fetch_pc+4, modulo 2^32 (0xFFFFFFFC+4 = 0x00000000).
- Update at posedge when upd_valid=1 and flush=0:
  - If the entry matches (valid, tag equal):
    - ctr increments if upd_taken, else decrements; saturates at 2'b11 and 2'b00.
    - target <= upd_target only if upd_taken.
  - If the entry misses and upd_taken=1:
    - Allocate or replace the entry: valid=1, tag, target=upd_target, ctr=2'b10 (weakly taken).
  - If the entry misses and upd_taken=0: no state change.
- flush=1 at posedge: all valid bits <= 0. Tags, targets and counters are retained but unused. flush overrides a same-cycle update.
- Lookup and update to the same index in the same cycle: the lookup returns pre-update state (no bypass). The new state is visible the cycle after the edge.
- Reset (rst=0, asynchronous, at any time including mid-update):
  - All valid <= 0, all ctr <= 2'b01, all targets and tags <= 0.
  - Outputs during/after reset: predict_taken=0, predicted_pc=fetch_pc+4, perf_hits=0, perf_allocs=0.
- Only one update port; at most one entry modified per cycle.

Optional Feature:
Macro BTB_PERF_EN.
- Defined:
  - perf_hits increments each posedge where fetch_valid && hit.
  - perf_allocs increments on each allocation, i.e. miss && upd_taken && upd_valid && !flush.
  - Both counters are 32-bit, wrap 0xFFFFFFFF -> 0, clear only on reset (not on flush).
- Undefined: counter flops are not built; perf_hits and perf_allocs are tied to 0. Port list is unchanged.

Test Plan:
- Reset, then fetch_pc=0x00000040 -> predict_taken=0, predicted_pc=0x00000044.
- Update upd_pc=0x40, upd_taken=1, upd_target=0x100; next cycle fetch_pc=0x40 -> predict_taken=1, predicted_pc=0x100. perf_allocs=1 with BTB_PERF_EN.
- Same entry, apply upd_taken=0 twice -> ctr 10->01->00. Lookup gives predict_taken=0, predicted_pc=0x44. Three taken updates then saturate at 11; a fourth leaves it at 11.
- Alias: ENTRIES=16, trained 0x40->0x100; lookup 0x440 (same idx, different tag) -> predict_taken=0. Taken update at 0x440->0x200 replaces the entry, so 0x40 now misses.
- Same cycle: fetch_pc=0x80 and first taken update of 0x80 -> predict_taken=0 that cycle, 1 the next. flush together with an update -> no allocation, all entries miss.
- Assert rst low mid-stream between edges -> predict_taken drops to 0 immediately (asynchronous); perf counters read 0.

Source files
------------

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is purely combinational from fetch_pc; training comes from the execute
// stage on the rising edge. Optional performance counters are built only when
// the macro BTB_PERF_EN is defined; otherwise perf_hits/perf_allocs read 0.
`timescale 1ns/1ps
module branch_target_buffer #(
    parameter int ENTRIES = 16,
    localparam int IDX_W = $clog2(ENTRIES),
    localparam int TAG_W = 30 - IDX_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    output logic        predict_taken,
    output logic [31:0] predicted_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        flush,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_allocs
);

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    // Saturating 2-bit direction counter step: toward 11 on taken, toward 00 otherwise.
    function automatic logic [1:0] ctr_sat_step(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'd1;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'd1;
    endfunction

    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic             fetch_hit;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_match;
    logic             alloc;

    assign fetch_idx = fetch_pc[IDX_W+1:2];
    assign fetch_tag = fetch_pc[31:IDX_W+2];
    assign upd_idx   = upd_pc[IDX_W+1:2];
    assign upd_tag   = upd_pc[31:IDX_W+2];

    // Lookup sees pre-edge state only; a same-cycle update is not bypassed.
    assign fetch_hit     = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign predict_taken = fetch_hit && ctr_q[fetch_idx][1];
    assign predicted_pc  = predict_taken ? target_q[fetch_idx] : fetch_pc + 32'd4;

    assign upd_match = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign alloc     = upd_valid && !flush && !upd_match && upd_taken;

    // Entry state: reset clears everything, flush drops valid bits and wins over training.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (upd_valid) begin
            if (upd_match) begin
                ctr_q[upd_idx] <= ctr_sat_step(ctr_q[upd_idx], upd_taken);
                if (upd_taken) begin
                    target_q[upd_idx] <= upd_target;
                end
            end else if (upd_taken) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target;
                ctr_q[upd_idx]    <= 2'b10;
            end
        end
    end

`ifdef BTB_PERF_EN
    logic [31:0] perf_hits_q;
    logic [31:0] perf_allocs_q;

    // Free-running wrap-around event counters; flush does not clear them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_hits_q   <= '0;
            perf_allocs_q <= '0;
        end else begin
            if (fetch_valid && fetch_hit) begin
                perf_hits_q <= perf_hits_q + 32'd1;
            end
            if (alloc) begin
                perf_allocs_q <= perf_allocs_q + 32'd1;
            end
        end
    end

    assign perf_hits   = perf_hits_q;
    assign perf_allocs = perf_allocs_q;

    logic unused_sink;
    assign unused_sink = ^upd_pc[1:0];
`else
    assign perf_hits   = '0;
    assign perf_allocs = '0;

    logic unused_sink;
    assign unused_sink = ^{fetch_valid, alloc, upd_pc[1:0]};
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios with literal
// expectations plus randomized traffic, all checked against an array-based model.
`timescale 1ns/1ps
module tb_branch_target_buffer;

    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        predict_taken;
    logic [31:0] predicted_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        flush;
    logic [31:0] perf_hits;
    logic [31:0] perf_allocs;

    int checks = 0;
    int errors = 0;

    branch_target_buffer #(.ENTRIES(ENTRIES)) dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .predict_taken(predict_taken), .predicted_pc(predicted_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .flush(flush),
        .perf_hits(perf_hits), .perf_allocs(perf_allocs)
    );

    always #5 clk = ~clk;

    // Reference model: one record per slot, counter kept as a plain integer 0..3.
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    int unsigned m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    int unsigned m_hits;
    int unsigned m_allocs;

    function automatic int m_index(input int unsigned pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int unsigned m_tagof(input int unsigned pc);
        return pc >> (2 + IDX_W);
    endfunction

    function automatic bit m_hit(input int unsigned pc);
        return m_valid[m_index(pc)] && (m_tag[m_index(pc)] == m_tagof(pc));
    endfunction

    function automatic bit m_pt(input int unsigned pc);
        return m_hit(pc) && (m_ctr[m_index(pc)] >= 2);
    endfunction

    function automatic int unsigned m_ppc(input int unsigned pc);
        return m_pt(pc) ? m_tgt[m_index(pc)] : pc + 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        m_hits = 0; m_allocs = 0;
    endtask

    // Applied right after each rising edge using the inputs the DUT just sampled.
    task automatic model_edge();
        int i;
        if (!rst) begin
            model_reset();
            return;
        end
`ifdef BTB_PERF_EN
        if (fetch_valid && m_hit(fetch_pc)) m_hits++;
`endif
        if (flush) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
        end else if (upd_valid) begin
            i = m_index(upd_pc);
            if (m_hit(upd_pc)) begin
                if (upd_taken) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = upd_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (upd_taken) begin
                m_valid[i] = 1; m_tag[i] = m_tagof(upd_pc); m_tgt[i] = upd_target; m_ctr[i] = 2;
`ifdef BTB_PERF_EN
                m_allocs++;
`endif
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("predict_taken", {31'd0, predict_taken}, {31'd0, m_pt(fetch_pc)});
        chk("predicted_pc", predicted_pc, m_ppc(fetch_pc));
        chk("perf_hits", perf_hits, m_hits);
        chk("perf_allocs", perf_allocs, m_allocs);
    endtask

    task automatic drive(input logic fv, input logic [31:0] fpc, input logic uv,
                         input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                         input logic fl);
        fetch_valid = fv; fetch_pc = fpc; upd_valid = uv; upd_pc = upc;
        upd_taken = ut; upd_target = utgt; flush = fl;
        #1;
        compare_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic look(input logic [31:0] pc);
        drive(1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        drive(1'b0, 32'h0, 1'b1, pc, taken, tgt, 1'b0);
        tick();
    endtask

    int unsigned rpc, upc_r;

    initial begin
        rst = 1'b0;
        fetch_valid = 0; fetch_pc = 0; upd_valid = 0; upd_pc = 0;
        upd_taken = 0; upd_target = 0; flush = 0;
        model_reset();
        @(negedge clk);
        look(32'h40);
        chk("reset_pt", {31'd0, predict_taken}, 32'd0);
        chk("reset_ppc", predicted_pc, 32'h44);
        chk("reset_perf_hits", perf_hits, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // First allocation then hit.
        train(32'h40, 1'b1, 32'h100);
        look(32'h40);
        chk("alloc_pt", {31'd0, predict_taken}, 32'd1);
        chk("alloc_ppc", predicted_pc, 32'h100);
`ifdef BTB_PERF_EN
        chk("alloc_count", perf_allocs, 32'd1);
`endif
        tick();

        // Walk counter down, then saturate up.
        train(32'h40, 1'b0, 32'h0);
        train(32'h40, 1'b0, 32'h0);
        look(32'h40);
        chk("ctr00_pt", {31'd0, predict_taken}, 32'd0);
        chk("ctr00_ppc", predicted_pc, 32'h44);
        tick();
        for (int k = 0; k < 4; k++) train(32'h40, 1'b1, 32'h100);
        look(32'h40);
        chk("sat11_pt", {31'd0, predict_taken}, 32'd1);
        tick();
        train(32'h40, 1'b0, 32'h0);
        look(32'h40);
        chk("sat_then_dec_pt", {31'd0, predict_taken}, 32'd1);
        chk("sat_then_dec_ppc", predicted_pc, 32'h100);
        tick();

        // Aliasing index with a different tag.
        look(32'h440);
        chk("alias_miss_pt", {31'd0, predict_taken}, 32'd0);
        chk("alias_miss_ppc", predicted_pc, 32'h444);
        tick();
        train(32'h440, 1'b1, 32'h200);
        look(32'h40);
        chk("replaced_pt", {31'd0, predict_taken}, 32'd0);
        tick();
        look(32'h440);
        chk("alias_hit_ppc", predicted_pc, 32'h200);
        tick();

        // Same-cycle lookup and first update: old state visible until the edge.
        drive(1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h300, 1'b0);
        chk("samecyc_pt", {31'd0, predict_taken}, 32'd0);
        chk("samecyc_ppc", predicted_pc, 32'h84);
        tick();
        look(32'h80);
        chk("nextcyc_ppc", predicted_pc, 32'h300);
        tick();

        // Flush with a simultaneous update: nothing allocated, everything misses.
        drive(1'b1, 32'h80, 1'b1, 32'hC0, 1'b1, 32'h400, 1'b1);
        tick();
        look(32'hC0);
        chk("flush_noalloc_pt", {31'd0, predict_taken}, 32'd0);
        tick();
        look(32'h80);
        chk("flush_miss_ppc", predicted_pc, 32'h84);
        tick();

        // Address wrap on fall-through.
        look(32'hFFFF_FFFC);
        chk("wrap_ppc", predicted_pc, 32'h0000_0000);
        tick();

        // Randomized traffic over a small PC pool so aliasing and hits are frequent.
        for (int n = 0; n < 600; n++) begin
            rpc   = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            upc_r = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            drive(1'($urandom_range(0, 3) != 0), rpc,
                  1'($urandom_range(0, 2) != 0), upc_r,
                  1'($urandom_range(0, 9) < 7), $urandom & 32'hFFFF_FFFC,
                  1'($urandom_range(0, 39) == 0));
            tick();
        end

        // Asynchronous reset between edges while a taken entry is being looked up.
        train(32'h80, 1'b1, 32'h500);
        train(32'h80, 1'b1, 32'h500);
        look(32'h80);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_pt", {31'd0, predict_taken}, 32'd0);
        chk("async_rst_ppc", predicted_pc, 32'h84);
        chk("async_rst_hits", perf_hits, 32'd0);
        chk("async_rst_allocs", perf_allocs, 32'd0);
        model_reset();
        tick();
        #2;
        rst = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 100; n++) begin
            rpc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
            drive(1'b1, rpc, 1'b1, rpc ^ 32'h40, 1'($urandom_range(0, 1)), $urandom, 1'b0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
